// File: rtl/s_term_edge_fifo_bridge_if.sv
// Stream bundle between the bottom fabric row, the south terminal bridge and
// its two possible consumers (external port and loopback path into the fabric).
interface s_term_edge_fifo_bridge_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  from_fab_valid;
    logic [DATA_WIDTH-1:0] from_fab_data;
    logic                  to_fab_ready;
    logic                  ext_valid;
    logic [DATA_WIDTH-1:0] ext_data;
    logic                  ext_ready;
    logic                  to_fab_valid;
    logic [DATA_WIDTH-1:0] to_fab_data;
    logic                  from_fab_ready;

    // Environment side: fabric producer plus both consumers.
    modport master (
        output from_fab_valid, from_fab_data, ext_ready, from_fab_ready,
        input  to_fab_ready, ext_valid, ext_data, to_fab_valid, to_fab_data
    );

    // Bridge side.
    modport slave (
        input  from_fab_valid, from_fab_data, ext_ready, from_fab_ready,
        output to_fab_ready, ext_valid, ext_data, to_fab_valid, to_fab_data
    );
endinterface

// File: rtl/s_term_edge_fifo_bridge.sv
// South-edge stream bridge: first-word-fall-through FIFO that forwards the
// fabric's south-bound stream either off-fabric or back north via loopback.
// The route is latched only while the FIFO is idle and empty, so a buffered
// burst never splits across destinations. A sticky flag records producers
// that drop or change a word while being stalled.
module s_term_edge_fifo_bridge #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                      UserCLK,
    input  logic                      resetn,
    s_term_edge_fifo_bridge_if.slave  bus,
    input  logic                      loop_en,
    input  logic                      clr_err,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wp;
    logic [AW-1:0]         rp;
    logic                  mode_q;
    logic                  resetn_q;
    logic                  stall_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;

    // Ready depends only on registered state, so a same-cycle pop never
    // frees a slot for a push; the producer sees no combinational path.
    assign empty            = (level == '0);
    assign full             = (level == FULL_LEVEL);
    assign bus.to_fab_ready = resetn_q && !full;
    assign push             = bus.from_fab_valid && bus.to_fab_ready;

    assign bus.ext_valid    = !empty && !mode_q;
    assign bus.to_fab_valid = !empty && mode_q;
    assign pop = (bus.ext_valid && bus.ext_ready) ||
                 (bus.to_fab_valid && bus.from_fab_ready);

    // Only the selected port carries the head word; everything else reads 0.
    assign head            = mem[rp];
    assign bus.ext_data    = bus.ext_valid    ? head : '0;
    assign bus.to_fab_data = bus.to_fab_valid ? head : '0;

    // Storage array write; contents are don't-care until pointed at by level.
    always_ff @(posedge UserCLK) begin
        if (push) begin
            mem[wp] <= bus.from_fab_data;
        end
    end

    // Pointers, occupancy, route latch, ready qualifier and protocol monitor.
    always_ff @(posedge UserCLK) begin
        if (!resetn) begin
            wp        <= '0;
            rp        <= '0;
            level     <= '0;
            mode_q    <= 1'b0;
            resetn_q  <= 1'b0;
            stall_q   <= 1'b0;
            data_q    <= '0;
            proto_err <= 1'b0;
        end else begin
            resetn_q <= 1'b1;

            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end

            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (empty && !push) begin
                mode_q <= loop_en;
            end

            stall_q <= bus.from_fab_valid && !bus.to_fab_ready;
            data_q  <= bus.from_fab_data;

            if (stall_q && (!bus.from_fab_valid || (bus.from_fab_data != data_q))) begin
                proto_err <= 1'b1;
            end else if (clr_err) begin
                proto_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_s_term_edge_fifo_bridge.sv
// Self-checking bench for s_term_edge_fifo_bridge: directed scenarios followed
// by randomized traffic, every cycle compared against a queue-based model.
module tb_s_term_edge_fifo_bridge;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          UserCLK = 1'b0;
    logic          resetn;
    logic          loop_en;
    logic          clr_err;
    logic [LW-1:0] level;
    logic          proto_err;

    s_term_edge_fifo_bridge_if #(.DATA_WIDTH(DW)) bus ();

    s_term_edge_fifo_bridge #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .UserCLK   (UserCLK),
        .resetn    (resetn),
        .bus       (bus),
        .loop_en   (loop_en),
        .clr_err   (clr_err),
        .level     (level),
        .proto_err (proto_err)
    );

    always #5 UserCLK = ~UserCLK;

    int checks = 0;
    int fails  = 0;

    // Reference model: a word queue plus the few pieces of history the
    // behaviour depends on (route, ready qualifier, last stall and word).
    logic [DW-1:0] mq[$];
    bit            m_mode;
    bit            m_rdy;
    bit            m_err;
    bit            m_stall;
    logic [DW-1:0] m_data;
    bit            m_pushed;

    // Compare one observed value against the expected one and count it.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit modelReady();
        return m_rdy && (mq.size() != DEPTH);
    endfunction

    // Drive one cycle of inputs, check all outputs mid-cycle, then advance the
    // model by the same clock edge the DUT sees.
    task automatic applyStimulus(input bit rn, input bit fv, input logic [DW-1:0] fd,
                                 input bit er, input bit fr, input bit le, input bit ce);
        int sz;
        bit rdy;
        bit push;
        bit pop;
        bit ev;
        bit tv;
        resetn              = rn;
        bus.from_fab_valid  = fv;
        bus.from_fab_data   = fd;
        bus.ext_ready       = er;
        bus.from_fab_ready  = fr;
        loop_en             = le;
        clr_err             = ce;
        @(negedge UserCLK);
        sz  = mq.size();
        rdy = modelReady();
        ev  = (sz != 0) && !m_mode;
        tv  = (sz != 0) && m_mode;
        checkOutput("level",        32'(level),            32'(sz));
        checkOutput("to_fab_ready", 32'(bus.to_fab_ready), 32'(rdy));
        checkOutput("ext_valid",    32'(bus.ext_valid),    32'(ev));
        checkOutput("to_fab_valid", 32'(bus.to_fab_valid), 32'(tv));
        checkOutput("ext_data",     32'(bus.ext_data),     ev ? 32'(mq[0]) : 32'd0);
        checkOutput("to_fab_data",  32'(bus.to_fab_data),  tv ? 32'(mq[0]) : 32'd0);
        checkOutput("proto_err",    32'(proto_err),        32'(m_err));
        m_pushed = 1'b0;
        if (!rn) begin
            mq.delete();
            m_mode  = 1'b0;
            m_rdy   = 1'b0;
            m_err   = 1'b0;
            m_stall = 1'b0;
            m_data  = '0;
        end else begin
            push = fv && rdy;
            pop  = (sz != 0) && (m_mode ? fr : er);
            if (m_stall && (!fv || fd != m_data)) m_err = 1'b1;
            else if (ce) m_err = 1'b0;
            m_stall = fv && !rdy;
            m_data  = fd;
            if (sz == 0 && !push) m_mode = le;
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(fd);
            m_pushed = push;
            m_rdy    = 1'b1;
        end
        @(posedge UserCLK);
        #1;
    endtask

    // Offer one word until the bridge takes it (bounded).
    task automatic pushWord(input logic [DW-1:0] d, input bit er, input bit fr, input bit le);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 1, d, er, fr, le, 0);
            if (m_pushed) return;
        end
        checkOutput("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n, input bit er, input bit fr, input bit le);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 8'h00, er, fr, le, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit            fv;
        logic [DW-1:0] fd;
        bit            le;

        // Bring-up: reset with unknown internal state, no checks yet.
        resetn = 0; loop_en = 0; clr_err = 0;
        bus.from_fab_valid = 0; bus.from_fab_data = '0;
        bus.ext_ready = 0; bus.from_fab_ready = 0;
        @(posedge UserCLK); @(posedge UserCLK); #1;
        mq.delete(); m_mode = 0; m_rdy = 0; m_err = 0; m_stall = 0; m_data = '0;

        // Reset values and ready qualification after release.
        applyStimulus(0, 0, 8'h00, 0, 0, 0, 0);
        checkOutput("rst_ready_low", 32'(bus.to_fab_ready), 32'd0);
        idle(1, 1, 0, 0);
        checkOutput("ready_up", 32'(bus.to_fab_ready), 32'd1);

        // Three words straight through to the external port.
        pushWord(8'h11, 1, 0, 0);
        checkOutput("first_word", 32'(bus.ext_data), 32'h11);
        pushWord(8'h22, 1, 0, 0);
        pushWord(8'h33, 1, 0, 0);
        idle(2, 1, 0, 0);
        checkOutput("drained", 32'(level), 32'd0);

        // Fill while external side stalls, hold the fifth word, then release.
        for (int i = 0; i < 4; i++) pushWord(8'h40 + 8'(i), 0, 0, 0);
        checkOutput("full_level", 32'(level), 32'd4);
        checkOutput("full_ready", 32'(bus.to_fab_ready), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 8'h44, 0, 0, 0, 0);
        pushWord(8'h44, 1, 0, 0);
        idle(6, 1, 0, 0);
        checkOutput("no_proto_err", 32'(proto_err), 32'd0);

        // Route change with two words buffered: burst stays on ext.
        pushWord(8'h51, 0, 0, 0);
        pushWord(8'h52, 0, 0, 0);
        idle(2, 0, 0, 1);
        checkOutput("route_hold", 32'(bus.ext_valid), 32'd1);
        idle(3, 1, 0, 1);
        pushWord(8'h61, 0, 1, 1);
        checkOutput("route_loop", 32'(bus.to_fab_valid), 32'd1);
        pushWord(8'h62, 0, 1, 1);
        idle(3, 0, 1, 0);

        // Protocol violation while stalled at full, then clear behaviour.
        for (int i = 0; i < 4; i++) pushWord(8'h70 + 8'(i), 0, 0, 0);
        applyStimulus(1, 1, 8'hA5, 0, 0, 0, 0);
        applyStimulus(1, 1, 8'h5A, 0, 0, 0, 0);
        checkOutput("proto_set", 32'(proto_err), 32'd1);
        applyStimulus(1, 1, 8'hA5, 0, 0, 0, 1);
        checkOutput("proto_set_wins", 32'(proto_err), 32'd1);
        applyStimulus(1, 1, 8'hA5, 0, 0, 0, 1);
        checkOutput("proto_clr", 32'(proto_err), 32'd0);
        pushWord(8'hA5, 1, 0, 0);

        // Reset mid-burst with three words buffered.
        idle(6, 1, 0, 0);
        for (int i = 0; i < 3; i++) pushWord(8'h80 + 8'(i), 0, 0, 0);
        applyStimulus(0, 1, 8'h90, 1, 1, 0, 0);
        checkOutput("rst_mid_level", 32'(level), 32'd0);
        checkOutput("rst_mid_valid", 32'(bus.ext_valid), 32'd0);
        checkOutput("rst_mid_ready", 32'(bus.to_fab_ready), 32'd0);
        idle(2, 1, 1, 0);

        // Randomized traffic, mostly well-behaved producer.
        fv = 0; fd = '0; le = 0;
        for (int c = 0; c < 2500; c++) begin
            bit rn;
            rn = ($urandom_range(0, 199) != 0);
            if (m_stall && $urandom_range(0, 29) != 0) begin
                // hold the stalled word
            end else if (m_stall && $urandom_range(0, 1) == 0) begin
                fv = 0;
            end else begin
                fv = ($urandom_range(0, 2) != 0);
                fd = DW'($urandom);
            end
            if ($urandom_range(0, 19) == 0) le = ~le;
            applyStimulus(rn, fv, fd, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
                          le, ($urandom_range(0, 24) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
